// File: rtl/qspi_flash_sequencer_pkg.sv
// qspi_flash_sequencer_pkg
// Shared definitions for the QSPI flash read sequencer and its AXI4-Lite
// single-transaction engine: bus widths, SPI controller register map,
// status bit positions, AXI response codes and the FSM state encodings.
package qspi_flash_sequencer_pkg;

  localparam int SPI_AXI_AW = 32;
  localparam int SPI_AXI_DW = 32;

  // Register map of the SPI controller behind the crossbar
  localparam int QSPI_REG_CMD  = 'h00;
  localparam int QSPI_REG_ADDR = 'h04;
  localparam int QSPI_REG_LEN  = 'h08;
  localparam int QSPI_REG_STAT = 'h0C;
  localparam int QSPI_REG_DATA = 'h10;

  // Status register bit positions
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_RXNE_BIT = 1;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_LEN,
    S_WR_CMD,
    S_POLL,
    S_RD_DATA,
    S_OUT,
    S_ERR
  } seq_state_e;

  typedef enum logic [1:0] {
    E_IDLE,
    E_WRITE,
    E_READ
  } eng_state_e;

  typedef enum logic {
    OP_WRITE,
    OP_READ
  } axi_op_e;

  // States in which the sequencer owns exactly one AXI transaction
  function automatic logic is_bus_state(input seq_state_e s);
    return (s == S_WR_ADDR) || (s == S_WR_LEN) || (s == S_WR_CMD) ||
           (s == S_POLL)    || (s == S_RD_DATA);
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if
// AXI4-Lite bundle. Modport m is the master side (drives AW/W/AR valids,
// bready, rready); modport s is the slave side.
interface axi4_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport m (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport s (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_single_master.sv
// axil_single_master
// Runs one AXI4-Lite read or write at a time.
// Ports:
//   aclk, areset  - clock, synchronous active-high reset
//   start         - launch a transaction (honoured only while idle)
//   op            - OP_WRITE or OP_READ
//   addr, wdata   - transaction address and write data
//   done          - one-cycle pulse after the B or R handshake
//   rdata, resp   - captured read data and response of the last transaction
//   bus           - AXI4-Lite master port
module axil_single_master
  import qspi_flash_sequencer_pkg::*;
#(
  parameter int AW = SPI_AXI_AW,
  parameter int DW = SPI_AXI_DW
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          start,
  input  axi_op_e       op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [1:0]    resp,
  axi4_lite_if.m        bus
);

  eng_state_e eng_state;
  eng_state_e eng_state_next;

  assign bus.awprot = 3'b000;
  assign bus.arprot = 3'b000;
  assign bus.wstrb  = '1;
  assign bus.bready = 1'b1;
  assign bus.rready = (eng_state == E_READ);

  always_ff @(posedge aclk) begin
    if (areset) begin
      eng_state <= E_IDLE;
    end else begin
      eng_state <= eng_state_next;
    end
  end

  // bready is always high, so bvalid alone completes a write
  always_comb begin
    eng_state_next = eng_state;
    case (eng_state)
      E_IDLE:  if (start) eng_state_next = (op == OP_WRITE) ? E_WRITE : E_READ;
      E_WRITE: if (bus.bvalid) eng_state_next = E_IDLE;
      E_READ:  if (bus.rvalid) eng_state_next = E_IDLE;
      default: eng_state_next = E_IDLE;
    endcase
  end

  // AW and W rise together but each drops on its own handshake
  always_ff @(posedge aclk) begin
    if (areset) begin
      bus.awaddr  <= '0;
      bus.awvalid <= 1'b0;
      bus.wdata   <= '0;
      bus.wvalid  <= 1'b0;
      bus.araddr  <= '0;
      bus.arvalid <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      resp        <= AXI_RESP_OKAY;
    end else begin
      done <= 1'b0;
      case (eng_state)
        E_IDLE: begin
          if (start) begin
            if (op == OP_WRITE) begin
              bus.awaddr  <= addr;
              bus.wdata   <= wdata;
              bus.awvalid <= 1'b1;
              bus.wvalid  <= 1'b1;
            end else begin
              bus.araddr  <= addr;
              bus.arvalid <= 1'b1;
            end
          end
        end
        E_WRITE: begin
          if (bus.awready) bus.awvalid <= 1'b0;
          if (bus.wready)  bus.wvalid  <= 1'b0;
          if (bus.bvalid) begin
            bus.awvalid <= 1'b0;
            bus.wvalid  <= 1'b0;
            done        <= 1'b1;
            resp        <= bus.bresp;
          end
        end
        E_READ: begin
          if (bus.arready) bus.arvalid <= 1'b0;
          if (bus.rvalid) begin
            bus.arvalid <= 1'b0;
            done        <= 1'b1;
            resp        <= bus.rresp;
            rdata       <= bus.rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/qspi_flash_sequencer.sv
// qspi_flash_sequencer
// Programs the SPI controller over AXI4-Lite (address, length, opcode),
// polls its status register and streams the received words out one at a
// time through a valid/ready port.
// Ports:
//   aclk, areset               - clock, synchronous active-high reset
//   cmd_valid/cmd_ready        - command handshake (ready only when idle)
//   cmd_opcode/addr/len        - flash opcode, byte address, word count
//   rd_data/rd_valid/rd_ready  - single-entry read word output
//   done, error                - one-cycle completion pulses
//   m_bus                      - AXI4-Lite master to the SPI register bus
module qspi_flash_sequencer
  import qspi_flash_sequencer_pkg::*;
#(
  parameter int AW         = SPI_AXI_AW,
  parameter int DW         = SPI_AXI_DW,
  parameter int REG_ADDR   = QSPI_REG_ADDR,
  parameter int REG_LEN    = QSPI_REG_LEN,
  parameter int REG_CMD    = QSPI_REG_CMD,
  parameter int REG_STAT   = QSPI_REG_STAT,
  parameter int REG_DATA   = QSPI_REG_DATA,
  parameter int POLL_LIMIT = 1024
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_opcode,
  input  logic [23:0]   cmd_addr,
  input  logic [15:0]   cmd_len,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          done,
  output logic          error,
  axi4_lite_if.m        m_bus
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  seq_state_e state;
  seq_state_e state_next;

  logic [7:0]    cmd_opcode_q;
  logic [23:0]   cmd_addr_q;
  logic [15:0]   cmd_len_q;
  logic [15:0]   rem_words;
  logic [PW-1:0] poll_cnt;
  logic [DW-1:0] rd_data_q;
  logic          done_q;
  logic          req_sent;

  logic          eng_start;
  axi_op_e       eng_op;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_wdata;
  logic          eng_done;
  logic [DW-1:0] eng_rdata;
  logic [1:0]    eng_resp;

  logic          cmd_capture;
  logic          poll_clr;
  logic          rd_load;
  logic          rem_dec;
  logic          done_set;

  axil_single_master #(
    .AW (AW),
    .DW (DW)
  ) u_engine (
    .aclk   (aclk),
    .areset (areset),
    .start  (eng_start),
    .op     (eng_op),
    .addr   (eng_addr),
    .wdata  (eng_wdata),
    .done   (eng_done),
    .rdata  (eng_rdata),
    .resp   (eng_resp),
    .bus    (m_bus)
  );

  assign cmd_ready = (state == S_IDLE);
  assign rd_valid  = (state == S_OUT);
  assign error     = (state == S_ERR);
  assign done      = done_q;
  assign rd_data   = rd_data_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Each bus state launches its transaction once (req_sent) and then waits
  // for the engine's done pulse; the poll counter advances per launched
  // status read so the limit equals the number of reads on the bus.
  always_comb begin
    state_next  = state;
    eng_start   = 1'b0;
    eng_op      = OP_READ;
    eng_addr    = '0;
    eng_wdata   = '0;
    cmd_capture = 1'b0;
    poll_clr    = 1'b0;
    rd_load     = 1'b0;
    rem_dec     = 1'b0;
    done_set    = 1'b0;

    if (is_bus_state(state) && !req_sent) begin
      eng_start = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_capture = 1'b1;
          state_next  = S_WR_ADDR;
        end
      end
      S_WR_ADDR: begin
        eng_op    = OP_WRITE;
        eng_addr  = AW'(REG_ADDR);
        eng_wdata = DW'({8'h00, cmd_addr_q});
        if (eng_done) state_next = (eng_resp == AXI_RESP_OKAY) ? S_WR_LEN : S_ERR;
      end
      S_WR_LEN: begin
        eng_op    = OP_WRITE;
        eng_addr  = AW'(REG_LEN);
        eng_wdata = DW'(cmd_len_q);
        if (eng_done) state_next = (eng_resp == AXI_RESP_OKAY) ? S_WR_CMD : S_ERR;
      end
      S_WR_CMD: begin
        eng_op    = OP_WRITE;
        eng_addr  = AW'(REG_CMD);
        eng_wdata = DW'(cmd_opcode_q);
        if (eng_done) state_next = (eng_resp == AXI_RESP_OKAY) ? S_POLL : S_ERR;
      end
      S_POLL: begin
        eng_addr = AW'(REG_STAT);
        if (eng_done) begin
          if (eng_resp != AXI_RESP_OKAY) begin
            state_next = S_ERR;
          end else if ((cmd_len_q == 16'd0) && !eng_rdata[STAT_BUSY_BIT]) begin
            done_set   = 1'b1;
            state_next = S_IDLE;
          end else if ((rem_words != 16'd0) && eng_rdata[STAT_RXNE_BIT]) begin
            state_next = S_RD_DATA;
          end else if (poll_cnt >= PW'(POLL_LIMIT)) begin
            state_next = S_ERR;
          end
        end
      end
      S_RD_DATA: begin
        eng_addr = AW'(REG_DATA);
        if (eng_done) begin
          if (eng_resp != AXI_RESP_OKAY) begin
            state_next = S_ERR;
          end else begin
            rd_load    = 1'b1;
            poll_clr   = 1'b1;
            state_next = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (rd_ready) begin
          rem_dec = 1'b1;
          if (rem_words <= 16'd1) begin
            done_set   = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_POLL;
          end
        end
      end
      S_ERR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cmd_opcode_q <= '0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      rem_words    <= '0;
      poll_cnt     <= '0;
      rd_data_q    <= '0;
      done_q       <= 1'b0;
      req_sent     <= 1'b0;
    end else begin
      done_q <= done_set;

      if (eng_start) begin
        req_sent <= 1'b1;
      end else if (eng_done) begin
        req_sent <= 1'b0;
      end

      if (cmd_capture) begin
        cmd_opcode_q <= cmd_opcode;
        cmd_addr_q   <= cmd_addr;
        cmd_len_q    <= cmd_len;
        rem_words    <= cmd_len;
      end else if (rem_dec && (rem_words != 16'd0)) begin
        rem_words <= rem_words - 16'd1;
      end

      if (cmd_capture || poll_clr) begin
        poll_cnt <= '0;
      end else if (eng_start && (state == S_POLL)) begin
        poll_cnt <= poll_cnt + PW'(1);
      end

      if (rd_load) begin
        rd_data_q <= eng_rdata;
      end
    end
  end

endmodule
